// File: rtl/alu_issue.sv
// Execute-stage ALU issue: add/sub/logic, borrow/overflow, one-hot compare controls, one register stage.
// Optional `ALU_ISSUE_SKID_EN adds a 1-entry skid buffer so in_ready_o does not depend on out_ready_i.
module alu_issue #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] tmp_rd_data_o,
  output logic            borrow_o,
  output logic            sub_overflow_o,
  output logic            rd_less_ctrl_o,
  output logic            rd_unsigned_less_ctrl_o,
  output logic            less_ctrl_o,
  output logic            less_unsigned_ctrl_o,
  output logic            nless_ctrl_o,
  output logic            nless_unsigned_ctrl_o,
  output logic            eq_ctrl_o,
  output logic            ieq_ctrl_o
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(13);

  // payload = {tmp, borrow, overflow, 8 one-hot controls}
  localparam int PW = XLEN + 10;

  logic [XLEN:0]   sub_sum;
  logic [XLEN-1:0] tmp_nxt;
  logic            is_sub;
  logic            borrow_nxt;
  logic            ovf_nxt;
  logic [7:0]      ctrl_nxt;
  logic [PW-1:0]   pay_nxt;
  logic [PW-1:0]   pay_q;
  logic            out_valid_q;
  logic            accept;
  logic            out_fire;

  always_comb begin
    sub_sum    = {1'b0, src1_i} + {1'b0, ~src2_i} + {{XLEN{1'b0}}, 1'b1};
    is_sub     = (op_i >= OP_SUB) && (op_i <= OP_BNE);
    borrow_nxt = is_sub & ~sub_sum[XLEN];
    ovf_nxt    = is_sub & (src1_i[XLEN-1] != src2_i[XLEN-1])
                        & (sub_sum[XLEN-1] != src1_i[XLEN-1]);
    tmp_nxt    = '0;
    ctrl_nxt   = '0;
    if (is_sub) tmp_nxt = sub_sum[XLEN-1:0];
    case (op_i)
      OP_ADD:  tmp_nxt = src1_i + src2_i;
      OP_SLT:  ctrl_nxt = 8'h80;
      OP_SLTU: ctrl_nxt = 8'h40;
      OP_BLT:  ctrl_nxt = 8'h20;
      OP_BLTU: ctrl_nxt = 8'h10;
      OP_BGE:  ctrl_nxt = 8'h08;
      OP_BGEU: ctrl_nxt = 8'h04;
      OP_BEQ:  ctrl_nxt = 8'h02;
      OP_BNE:  ctrl_nxt = 8'h01;
      OP_AND:  tmp_nxt = src1_i & src2_i;
      OP_OR:   tmp_nxt = src1_i | src2_i;
      OP_XOR:  tmp_nxt = src1_i ^ src2_i;
      OP_PASS: tmp_nxt = src2_i;
      default: ;
    endcase
    pay_nxt = {tmp_nxt, borrow_nxt, ovf_nxt, ctrl_nxt};
  end

  assign accept   = in_valid_i & in_ready_o;
  assign out_fire = out_valid_q & out_ready_i;

`ifdef ALU_ISSUE_SKID_EN
  logic          skid_valid_q;
  logic [PW-1:0] skid_q;

  // Ready comes from the skid flag only; flush still blocks acceptance for its cycle.
  assign in_ready_o = ~skid_valid_q & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      pay_q        <= '0;
      skid_q       <= '0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        pay_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_fire) begin
        pay_q       <= pay_nxt;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= pay_nxt;
        skid_valid_q <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end
`else
  assign in_ready_o = ~flush_i & (~out_valid_q | out_ready_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      pay_q       <= '0;
    end else begin
      if (flush_i)       out_valid_q <= 1'b0;
      else if (accept)   out_valid_q <= 1'b1;
      else if (out_fire) out_valid_q <= 1'b0;
      if (accept) pay_q <= pay_nxt;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign {tmp_rd_data_o, borrow_o, sub_overflow_o,
          rd_less_ctrl_o, rd_unsigned_less_ctrl_o,
          less_ctrl_o, less_unsigned_ctrl_o,
          nless_ctrl_o, nless_unsigned_ctrl_o,
          eq_ctrl_o, ieq_ctrl_o} = pay_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected payloads queued on accept, compared on each output transfer.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] src1, src2, tmp;
  logic        borrow, ovf;
  logic        rd_less, rd_uless, less, less_u, nless, nless_u, eq, ieq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [41:0] sb_q[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .src1_i(src1), .src2_i(src2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .tmp_rd_data_o(tmp), .borrow_o(borrow), .sub_overflow_o(ovf),
    .rd_less_ctrl_o(rd_less), .rd_unsigned_less_ctrl_o(rd_uless),
    .less_ctrl_o(less), .less_unsigned_ctrl_o(less_u),
    .nless_ctrl_o(nless), .nless_unsigned_ctrl_o(nless_u),
    .eq_ctrl_o(eq), .ieq_ctrl_o(ieq)
  );

  wire [41:0] obs = {tmp, borrow, ovf, rd_less, rd_uless, less, less_u, nless, nless_u, eq, ieq};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 32-bit arithmetic, unsigned compare for borrow, 64-bit signed range for overflow.
  function automatic logic [41:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    logic        br, ov;
    logic [7:0]  c;
    longint      sd;
    t = 0; br = 0; ov = 0; c = 0;
    if (o >= 1 && o <= 9) begin
      t  = a - b;
      br = (a < b);
      sd = longint'($signed(a)) - longint'($signed(b));
      ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    end
    case (o)
      4'd0:  t = a + b;
      4'd2:  c = 8'h80;
      4'd3:  c = 8'h40;
      4'd4:  c = 8'h20;
      4'd5:  c = 8'h10;
      4'd6:  c = 8'h08;
      4'd7:  c = 8'h04;
      4'd8:  c = 8'h02;
      4'd9:  c = 8'h01;
      4'd10: t = a & b;
      4'd11: t = a | b;
      4'd12: t = a ^ b;
      4'd13: t = b;
      default: ;
    endcase
    return {t, br, ov, c};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else check("payload", 64'(obs), 64'(sb_q.pop_front()));
    end
  end

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [41:0] exp, input bit rnd);
    int n;
    bit done;
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    n = 0; done = 0;
    while (!done && n < 64) begin
      @(negedge clk); n++;
      if (in_ready) begin sb_q.push_back(exp); done = 1; end
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 64) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int n;
    logic [31:0] a, b;
    logic [3:0]  o;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; op = 0; src1 = 0; src2 = 0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_payload", 64'(obs), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // directed cases
    send(4'd2, 32'hFFFF_FFFB, 32'h3, {32'hFFFF_FFF8, 1'b0, 1'b0, 8'h80}, 0);
    check("latency_valid", 64'(out_valid), 64'd1);
    send(4'd3, 32'h1, 32'h2, {32'hFFFF_FFFF, 1'b1, 1'b0, 8'h40}, 0);
    send(4'd1, 32'h8000_0000, 32'h1, {32'h7FFF_FFFF, 1'b0, 1'b1, 8'h00}, 0);
    send(4'd8, 32'h5, 32'h5, {32'h0, 1'b0, 1'b0, 8'h02}, 0);
    send(4'd9, 32'h5, 32'h6, {32'hFFFF_FFFF, 1'b1, 1'b0, 8'h01}, 0);
    send(4'd10, 32'hF0F0, 32'h0FF0, {32'h0000_00F0, 1'b0, 1'b0, 8'h00}, 0);
    drain();

    // stall: ADD 1+2 held, ADD 3+4 waiting
    out_ready = 0;
    send(4'd0, 32'd1, 32'd2, model(4'd0, 32'd1, 32'd2), 0);
    op = 4'd0; src1 = 32'd3; src2 = 32'd4; in_valid = 1; acc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_tmp", 64'(tmp), 64'd3);
      check("stall_valid", 64'(out_valid), 64'd1);
`ifdef ALU_ISSUE_SKID_EN
      check("stall_ready", 64'(in_ready), 64'(i == 0));
`else
      check("stall_ready", 64'(in_ready), 64'd0);
`endif
      if (in_ready && !acc) begin sb_q.push_back(model(4'd0, 32'd3, 32'd4)); acc = 1; end
      @(posedge clk); #1;
      if (acc) in_valid = 0;
    end
    out_ready = 1;
    n = 0;
    while (!acc && n < 16) begin
      @(negedge clk); n++;
      if (in_ready) begin sb_q.push_back(model(4'd0, 32'd3, 32'd4)); acc = 1; end
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("stall_accept", 64'(acc), 64'd1);
    drain();

    // flush while stalled
    out_ready = 0;
    send(4'd11, 32'hA0, 32'h05, model(4'd11, 32'hA0, 32'h05), 0);
    check("flush_pre_valid", 64'(out_valid), 64'd1);
    flush = 1; in_valid = 1; op = 4'd12; src1 = 32'h1; src2 = 32'h2;
    @(negedge clk);
    check("flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb_q.delete();
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // async reset mid-stall
    out_ready = 0;
    send(4'd1, 32'h8000_0000, 32'h1, model(4'd1, 32'h8000_0000, 32'h1), 0);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_payload", 64'(obs), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1;
    #1 check("post_rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1;
    send(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 42'd0, 0);
    send(4'd15, 32'h1, 32'h2, model(4'd15, 32'h1, 32'h2), 0);
    drain();

    // random ops with random backpressure
    for (int k = 0; k < 60; k++) begin
      o = 4'($urandom_range(0, 15));
      a = (k % 5 == 0) ? 32'h8000_0000 : $urandom;
      b = (k % 7 == 0) ? a : ((k % 3 == 0) ? 32'h7FFF_FFFF : $urandom);
      send(o, a, b, model(o, a, b), 1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
